// File: rtl/simon_pkg.sv
// Shared types for the Simon Says game sequencer.
// Contents:
//   state_t    - top-level sequencer states
//   sym_t      - 2-bit pattern symbol
//   sym_onehot - maps a symbol to its one-hot LED / switch code
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_WAIT_IN,
        ST_LOSE,
        ST_WIN
    } state_t;

    typedef logic [1:0] sym_t;

    function automatic logic [3:0] sym_onehot(input sym_t s);
        logic [3:0] w_base;
        w_base = 4'b0001;
        return w_base << s;
    endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Player-facing signal bundle of the Simon sequencer.
// slave  (sequencer): start, in_sym, in_done in; input_en, show_led, level,
//                     busy, game_over, win out.
// master (board / input block side): the mirror image.
interface simon_game_ctrl_if #(
    parameter int MAX_LEVEL = 16
) ();
    localparam int LVL_W = $clog2(MAX_LEVEL + 1);

    logic             start;
    logic [3:0]       in_sym;
    logic             in_done;
    logic             input_en;
    logic [3:0]       show_led;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             game_over;
    logic             win;

    modport master (
        output start, in_sym, in_done,
        input  input_en, show_led, level, busy, game_over, win
    );

    modport slave (
        input  start, in_sym, in_done,
        output input_en, show_led, level, busy, game_over, win
    );
endinterface

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the pattern symbol source.
// Ports: clk, reset (sync, active-high, reloads SEED), out[7:0] state.
// SEED must be non-zero or the register sticks at zero.
module simon_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] out
);
    always_ff @(posedge clk) begin
        if (reset) out <= SEED;
        else       out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
    end
endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says top-level sequencer: grows a random pattern one symbol per
// round, plays it on four LEDs, then checks the player's entries.
// Ports: clk, reset (sync, active-high), bus (simon_game_ctrl_if.slave).
// All outputs decode registered state only.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// ADD      | append one LFSR symbol to the pattern, level+1
// SHOW_ON  | LED for pattern[idx] lit for SHOW_CYCLES
// SHOW_OFF | dark gap for GAP_CYCLES, then next symbol or input
// WAIT_IN  | input enabled, check each entry against pattern[idx]
// LOSE     | wrong entry or timeout, waiting for start
// WIN      | MAX_LEVEL round completed, waiting for start
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int         MAX_LEVEL      = 16,
    parameter int         SHOW_CYCLES    = 25_000_000,
    parameter int         GAP_CYCLES     = 12_500_000,
    parameter int         TIMEOUT_CYCLES = 250_000_000,
    parameter logic [7:0] SEED           = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    simon_game_ctrl_if.slave  bus
);
    localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
    localparam int IDX_W  = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
    localparam int T_MAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
    localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t           r_state, w_state_nxt;
    logic [LVL_W-1:0] r_level, w_level_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic             r_in_done_q;
    sym_t             r_mem [MAX_LEVEL];
    logic             w_mem_we;
    logic [7:0]       w_lfsr;
    logic             w_ev;
    logic             w_last;
    logic [3:0]       w_cur_oh;

    simon_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (w_lfsr)
    );

    assign w_ev     = bus.in_done & ~r_in_done_q;
    assign w_last   = (LVL_W'(r_idx) == r_level - 1'b1);
    assign w_cur_oh = sym_onehot(r_mem[r_idx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_level     <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_in_done_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_idx       <= w_idx_nxt;
            r_timer     <= w_timer_nxt;
            r_in_done_q <= bus.in_done;
        end
    end

    // Pattern storage is never cleared; ADD overwrites each slot before use.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_level[IDX_W-1:0]] <= w_lfsr[1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_mem_we    = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOSE, ST_WIN: begin
                if (bus.start) begin
                    w_state_nxt = ST_ADD;
                    w_level_nxt = '0;
                end
            end
            ST_ADD: begin
                w_mem_we    = 1'b1;
                w_level_nxt = r_level + 1'b1;
                w_idx_nxt   = '0;
                w_timer_nxt = '0;
                w_state_nxt = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (r_timer == TMR_W'(SHOW_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_SHOW_OFF;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_SHOW_OFF: begin
                if (r_timer == TMR_W'(GAP_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_WAIT_IN;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = ST_SHOW_ON;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_WAIT_IN: begin
                // An entry in the timeout cycle wins over the timeout.
                if (w_ev) begin
                    if (bus.in_sym == w_cur_oh) begin
                        if (w_last) begin
                            w_state_nxt = (r_level == LVL_W'(MAX_LEVEL)) ? ST_WIN : ST_ADD;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_timer_nxt = '0;
                        end
                    end else begin
                        w_state_nxt = ST_LOSE;
                    end
                end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_LOSE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.show_led  = (r_state == ST_SHOW_ON) ? w_cur_oh : 4'b0000;
    assign bus.input_en  = (r_state == ST_WAIT_IN);
    assign bus.level     = r_level;
    assign bus.busy      = (r_state != ST_IDLE) && (r_state != ST_LOSE) && (r_state != ST_WIN);
    assign bus.game_over = (r_state == ST_LOSE);
    assign bus.win       = (r_state == ST_WIN);
endmodule

// File: doc/simon_game_ctrl.md
# simon_game_ctrl

Top-level sequencer for the Simon Says game. Grows a pseudo-random pattern one symbol per round, plays it back on four LEDs, and enables the switch-input block. It checks each entered symbol against the pattern and ends the game in a win or loss state. It sits between the switch-input block (drives its `on_off`, consumes `to_cmp`/`input_done`) and the board LEDs.

## Interface
- `MAX_LEVEL`, 16: pattern length needed to win (1..32).
- `SHOW_CYCLES`, 25_000_000: cycles each symbol LED is lit during playback.
- `GAP_CYCLES`, 12_500_000: dark cycles after each played symbol.
- `TIMEOUT_CYCLES`, 250_000_000: max cycles allowed per player entry.
- `SEED`, 8'hA5: LFSR reset value; must be non-zero.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; begins a new game when in IDLE, LOSE or WIN.
- `in_sym`  in  4  entered switch code (`to_cmp` of input block).
- `in_done`  in  1  level from input block; a new entry is its rising edge.
- `input_en`  out  1  drives input block `on_off`.
- `show_led`  out  4  one-hot playback LEDs.
- `level`  out  $clog2(MAX_LEVEL+1)  current pattern length.
- `busy`  out  1  high in every state except IDLE, LOSE, WIN.
- `game_over`  out  1  high in LOSE.
- `win`  out  1  high in WIN.

## Operation
- Reset: state IDLE, `level`=0, idx=0, timer=0, in_done_q=0, lfsr=SEED. All outputs are 0.
- LFSR: 8-bit, free-running every cycle in all states: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. New symbol = lfsr[1:0].
- Pattern memory: MAX_LEVEL x 2-bit registers. Symbol s displays as one-hot 4'b0001<<s.
- Entry event `ev` = in_done & ~in_done_q. in_done_q is registered every cycle.
- States and transitions:
  - IDLE / LOSE / WIN: start=1 → ADD. Clear `level` to 0. game_over/win drop with the state change.
  - ADD: mem[level] <= lfsr[1:0]; level+1; idx=0; timer=0 → SHOW_ON.
  - SHOW_ON: show_led=onehot(mem[idx]). After SHOW_CYCLES cycles → SHOW_OFF with timer=0.
  - SHOW_OFF: show_led=0. After GAP_CYCLES cycles:
    - if idx==level-1 → WAIT_IN with idx=0, timer=0;
    - else idx+1 → SHOW_ON.
  - WAIT_IN: input_en=1; timer increments.
    - On ev with in_sym==onehot(mem[idx]):
      - last symbol of a round at level==MAX_LEVEL → WIN;
      - last symbol of any other round → ADD;
      - otherwise idx+1, timer=0.
    - On ev with any other in_sym (including multi-hot or zero) → LOSE.
    - No ev by timer==TIMEOUT_CYCLES-1 → LOSE.
- Simultaneous ev and timeout: ev takes priority.
- start is ignored while busy.
- reset in any state aborts immediately to the reset values. The pattern memory is not cleared; it is overwritten by ADD.
- Leaving WAIT_IN drops input_en, which clears the input block before the next round.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- start high in IDLE at edge N: ADD during cycle N+1, first LED lit in cycle N+2.
- Each played symbol occupies exactly SHOW_CYCLES + GAP_CYCLES cycles.
- input_en rises one cycle after the final gap of a round ends.
- in_done rising in cycle K is evaluated in K. The state or idx update is visible in K+1.
- in_done held high produces only one ev. A repeat entry needs in_done to drop first.
- Round r (level=r) playback takes r*(SHOW_CYCLES+GAP_CYCLES) cycles.

## Structure
- Package `simon_pkg`:
  - state enum (IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN);
  - `sym_t` = logic[1:0];
  - function `sym_onehot(sym_t)` returning logic[3:0].
- Sub-module `simon_lfsr`: parameter SEED; ports clk, reset, out[7:0].
- Timer width is $clog2 of the largest of the three cycle parameters.

## Test plan
Bench parameters: MAX_LEVEL=3, SHOW=4, GAP=2, TIMEOUT=40, SEED=8'hA5. The bench uses a reference LFSR model.
- Reset asserted mid-SHOW_ON → next cycle: all outputs 0, level=0, IDLE; lfsr restarts at 8'hA5.
- start pulse in IDLE → level=1, show_led one-hot for exactly 4 cycles, 0 for 2, then input_en=1.
- Correct entries for rounds 1..3 (in_done pulses after release) → level steps 1→2→3, then win=1, busy=0, input_en=0.
- Wrong in_sym=4'b0110 on first entry of round 2 → game_over=1 next cycle, level stays 2.
- No entry for 40 cycles in WAIT_IN → game_over=1 at cycle 41. Entry and timeout in the same cycle with a correct symbol → no loss.
- in_done held high for 10 cycles → one entry counted. start during playback is ignored. start in LOSE → level=1 with a new pattern.
